// File: rtl/acc_cmd_dispatcher_pkg.sv
// Shared accelerator ISA constants, dispatcher FSM states and decode helpers.
package acc_cmd_dispatcher_pkg;

    // Major opcode for accelerator-extension instructions (custom-0 slot).
    localparam logic [6:0] INST_ACC = 7'b0001011;

    // funct3 encodings of the accelerator operations.
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_SAVE   = 3'b001;
    localparam logic [2:0] OP_MATMUL = 3'b010;
    localparam logic [2:0] OP_RESET  = 3'b011;
    localparam logic [2:0] OP_MOVE   = 3'b100;
    localparam logic [2:0] OP_SYNC   = 3'b111;

    localparam int unsigned OP_W = 3;
    localparam int unsigned RD_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_SYNC_WAIT = 2'd2
    } disp_state_e;

    // True for operations that travel through the command queue.
    function automatic logic is_queued_op(input logic [2:0] f3);
        case (f3)
            OP_LOAD, OP_SAVE, OP_MATMUL, OP_RESET, OP_MOVE: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acc_cmd_fifo.sv
// Command queue: power-of-two depth, extra pointer bit distinguishes full from empty.
module acc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; wrap comes for free from the power-of-two width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero while idle after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/acc_cmd_dispatcher.sv
// Accelerator command dispatcher: decodes accelerator instructions in ID, queues
// their operands, issues them over valid/ready and tracks in-flight MATMULs.
module acc_cmd_dispatcher
    import acc_cmd_dispatcher_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [2:0]      cmd_op,
    output logic [XLEN-1:0] cmd_rs1,
    output logic [XLEN-1:0] cmd_rs2,
    output logic [4:0]      cmd_rd,
    input  logic            acc_done,
    output logic            busy,
    output logic            illegal,
    output logic            err_done
);

    localparam int OUT_W   = $clog2(MAX_OUT + 1);
    localparam int ENTRY_W = OP_W + 2 * XLEN + RD_W;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    // Decode
    logic              is_acc;
    logic [2:0]        funct3;
    logic              op_queued;
    logic              op_sync;
    logic              unused_instr_hi;

    // Queue interface
    logic              enq;
    logic              deq;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_head;
    logic [2:0]        head_op;
    logic [XLEN-1:0]   head_rs1;
    logic [XLEN-1:0]   head_rs2;
    logic [4:0]        head_rd;

    // Control state
    disp_state_e       state;
    disp_state_e       state_nxt;
    logic [OUT_W-1:0]  outstanding;
    logic              drained;
    logic              mm_issue;

    assign is_acc          = instr_valid && (instr[6:0] == INST_ACC);
    assign funct3          = instr[14:12];
    assign op_queued       = is_queued_op(funct3);
    assign op_sync         = (funct3 == OP_SYNC);
    assign unused_instr_hi = ^instr[XLEN-1:15];

    assign fifo_wdata = {funct3, rs1_data, rs2_data, instr[11:7]};
    assign {head_op, head_rs1, head_rs2, head_rd} = fifo_head;

    acc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (enq),
        .wdata (fifo_wdata),
        .pop   (deq),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign drained   = fifo_empty && (outstanding == '0);
    // A MATMUL at the head waits while the accelerator already holds MAX_OUT of them.
    assign cmd_valid = !fifo_empty && !((head_op == OP_MATMUL) && (outstanding == OUT_MAX));
    assign deq       = cmd_valid && cmd_ready;
    assign mm_issue  = deq && (head_op == OP_MATMUL);

    assign cmd_op  = head_op;
    assign cmd_rs1 = head_rs1;
    assign cmd_rs2 = head_rs2;
    assign cmd_rd  = head_rd;
    assign busy    = !fifo_empty || (outstanding != '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Enqueue/stall decision and barrier sequencing.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        enq       = 1'b0;

        // A full queue blocks the push even when the head leaves this same cycle.
        if (is_acc && op_queued) begin
            if (fifo_full || (state == ST_SYNC_WAIT)) stall = 1'b1;
            else                                      enq   = 1'b1;
        end
        if (is_acc && op_sync && !drained) stall = 1'b1;

        case (state)
            ST_IDLE: begin
                if (enq) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (is_acc && op_sync && !drained) state_nxt = ST_SYNC_WAIT;
                else if (drained && !enq)          state_nxt = ST_IDLE;
            end
            ST_SYNC_WAIT: begin
                if (drained) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In-flight MATMUL count; a simultaneous issue and completion cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else if (mm_issue && !acc_done) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!mm_issue && acc_done && (outstanding != '0)) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    // Sticky flag for a completion that has no MATMUL to retire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                 err_done <= 1'b0;
        else if (acc_done && (outstanding == '0))  err_done <= 1'b1;
    end

    // One-cycle pulse for accelerator instructions with an unknown funct3.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) illegal <= 1'b0;
        else       illegal <= is_acc && !op_queued && !op_sync;
    end

endmodule
